// File: rtl/network_pkg.sv
// Shared definitions for the LSTM weight loader: width helpers, RAM-select
// encoding, bias one-hot codes and the loader state enumeration.
package network_pkg;

    // Q(QN.QM) word plus sign bit
    function automatic int calc_bitwidth(input int qn, input int qm);
        return qn + qm + 1;
    endfunction

    function automatic int calc_layer_bitwidth(input int bitwidth, input int hidden_sz);
        return bitwidth * hidden_sz;
    endfunction

    function automatic int calc_addr_bitwidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Target RAM select; block index 0..7 maps directly onto these codes
    localparam logic [2:0] SEL_Z_X = 3'd0;
    localparam logic [2:0] SEL_Z_Y = 3'd1;
    localparam logic [2:0] SEL_I_X = 3'd2;
    localparam logic [2:0] SEL_I_Y = 3'd3;
    localparam logic [2:0] SEL_F_X = 3'd4;
    localparam logic [2:0] SEL_F_Y = 3'd5;
    localparam logic [2:0] SEL_O_X = 3'd6;
    localparam logic [2:0] SEL_O_Y = 3'd7;

    localparam logic [3:0] BIAS_Z = 4'b0001;
    localparam logic [3:0] BIAS_I = 4'b0010;
    localparam logic [3:0] BIAS_F = 4'b0100;
    localparam logic [3:0] BIAS_O = 4'b1000;

    localparam int NUM_RAM_BLOCKS = 8;
    localparam int NUM_BLOCKS     = 12;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone
    } load_state_t;

    function automatic logic [3:0] bias_onehot(input logic [1:0] idx);
        logic [3:0] code;
        unique case (idx)
            2'd0:    code = BIAS_Z;
            2'd1:    code = BIAS_I;
            2'd2:    code = BIAS_F;
            default: code = BIAS_O;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/network_weight_loader_row_assembler.sv
// HIDDEN_SZ-word row buffer. Words are inserted at the current column; the
// row including the word being accepted is exposed combinationally so the
// caller can capture a complete row on the final-word edge.
module row_assembler
    import network_pkg::*;
#(
    parameter int HIDDEN_SZ      = 8,
    parameter int BITWIDTH       = 18,
    parameter int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ,
    parameter int ADDR_BITWIDTH  = calc_addr_bitwidth(HIDDEN_SZ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      accept,
    input  logic [BITWIDTH-1:0]       data,
    output logic [LAYER_BITWIDTH-1:0] row_next,
    output logic                      row_done
);

    localparam logic [ADDR_BITWIDTH-1:0] LAST_COL = ADDR_BITWIDTH'(HIDDEN_SZ - 1);

    logic [LAYER_BITWIDTH-1:0] buffer;
    logic [ADDR_BITWIDTH-1:0]  col;

    // Current buffer with the incoming word dropped into its column slot
    always_comb begin
        row_next = buffer;
        for (int j = 0; j < HIDDEN_SZ; j++) begin
            if (col == ADDR_BITWIDTH'(j)) begin
                row_next[j*BITWIDTH +: BITWIDTH] = data;
            end
        end
    end

    assign row_done = accept && (col == LAST_COL);

    // Column counter and buffer advance only on an accepted word
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            buffer <= '0;
            col    <= '0;
        end else if (accept) begin
            buffer <= row_next;
            col    <= row_done ? '0 : col + ADDR_BITWIDTH'(1);
        end
    end

endmodule

// File: rtl/network_weight_loader.sv
// Streams the full LSTM parameter image (W/R matrices, then biases) from a
// valid/ready word source into the network RAM row ports and bias registers.
module network_weight_loader
    import network_pkg::*;
#(
    parameter int INPUT_SZ       = 2,
    parameter int HIDDEN_SZ      = 8,
    parameter int QN             = 6,
    parameter int QM             = 11,
    parameter int BITWIDTH       = calc_bitwidth(QN, QM),
    parameter int LAYER_BITWIDTH = calc_layer_bitwidth(BITWIDTH, HIDDEN_SZ),
    parameter int ADDR_BITWIDTH  = calc_addr_bitwidth(HIDDEN_SZ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [BITWIDTH-1:0]       in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      wr_en,
    output logic [2:0]                wr_sel,
    output logic [ADDR_BITWIDTH-1:0]  wr_addr,
    output logic [LAYER_BITWIDTH-1:0] wr_data,
    output logic [3:0]                bias_we,
    output logic [LAYER_BITWIDTH-1:0] bias_data,
    output logic                      busy,
    output logic                      done
);

    // W blocks may have more rows than R blocks if INPUT_SZ > HIDDEN_SZ
    localparam int ROW_BITWIDTH = (INPUT_SZ > HIDDEN_SZ) ? calc_addr_bitwidth(INPUT_SZ)
                                                         : ADDR_BITWIDTH;

    load_state_t               state;
    logic [3:0]                blk;
    logic [ROW_BITWIDTH-1:0]   row;
    logic                      accept;
    logic                      asm_clear;
    logic                      row_done;
    logic                      last_row;
    logic                      last_blk;
    logic [LAYER_BITWIDTH-1:0] row_next;
    int                        rows_in_blk;

    assign accept    = in_valid && in_ready;
    assign asm_clear = (state != StLoad) && start;

    // Row count of the current block: W has INPUT_SZ rows, R has HIDDEN_SZ, a bias is one row
    always_comb begin
        rows_in_blk = 1;
        if (blk < 4'(NUM_RAM_BLOCKS)) begin
            rows_in_blk = blk[0] ? HIDDEN_SZ : INPUT_SZ;
        end
        last_row = (int'(row) == rows_in_blk - 1);
        last_blk = (blk == 4'(NUM_BLOCKS - 1));
    end

    row_assembler #(
        .HIDDEN_SZ      (HIDDEN_SZ),
        .BITWIDTH       (BITWIDTH),
        .LAYER_BITWIDTH (LAYER_BITWIDTH),
        .ADDR_BITWIDTH  (ADDR_BITWIDTH)
    ) u_row_assembler (
        .clock    (clock),
        .reset    (reset),
        .clear    (asm_clear),
        .accept   (accept),
        .data     (in_data),
        .row_next (row_next),
        .row_done (row_done)
    );

    // Load FSM with block/row counters and registered write/handshake outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= StIdle;
            blk       <= '0;
            row       <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_en     <= 1'b0;
            wr_sel    <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            bias_we   <= '0;
            bias_data <= '0;
        end else begin
            // Strobes are single-cycle; data/select registers hold between writes
            wr_en   <= 1'b0;
            bias_we <= '0;
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state    <= StLoad;
                        blk      <= '0;
                        row      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                StLoad: begin
                    if (row_done) begin
                        if (blk < 4'(NUM_RAM_BLOCKS)) begin
                            wr_en   <= 1'b1;
                            wr_sel  <= blk[2:0];
                            wr_addr <= ADDR_BITWIDTH'(row);
                            wr_data <= row_next;
                        end else begin
                            bias_we   <= bias_onehot(blk[1:0]);
                            bias_data <= row_next;
                        end
                        if (last_row) begin
                            row <= '0;
                            if (last_blk) begin
                                state    <= StDone;
                                blk      <= '0;
                                in_ready <= 1'b0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                            end else begin
                                blk <= blk + 4'd1;
                            end
                        end else begin
                            row <= row + ROW_BITWIDTH'(1);
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_network_weight_loader.sv
// Self-checking bench for network_weight_loader: a scoreboard of expected row
// and bias writes is filled as words are accepted and drained by a strobe monitor.
module tb_network_weight_loader;

    localparam int INPUT_SZ  = 2;
    localparam int HIDDEN_SZ = 8;
    localparam int BW        = 18;
    localparam int LW        = BW * HIDDEN_SZ;
    localparam int AW        = 3;
    localparam int PER_GATE  = INPUT_SZ * HIDDEN_SZ + HIDDEN_SZ * HIDDEN_SZ;
    localparam int TOTAL     = 4 * PER_GATE + 4 * HIDDEN_SZ;
    localparam int NUM_WR    = 4 * (INPUT_SZ + HIDDEN_SZ);

    logic          clock;
    logic          reset;
    logic          start;
    logic [BW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          wr_en;
    logic [2:0]    wr_sel;
    logic [AW-1:0] wr_addr;
    logic [LW-1:0] wr_data;
    logic [3:0]    bias_we;
    logic [LW-1:0] bias_data;
    logic          busy;
    logic          done;

    network_weight_loader #(
        .INPUT_SZ  (INPUT_SZ),
        .HIDDEN_SZ (HIDDEN_SZ),
        .QN        (6),
        .QM        (11)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .bias_we   (bias_we),
        .bias_data (bias_data),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit            is_bias;
        int            blk;
        int            row;
        logic [LW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    int            bias_order[$];
    int            checks_total  = 0;
    int            checks_passed = 0;
    int            wr_cnt        = 0;
    int            bias_cnt      = 0;
    logic [LW-1:0] ram_img  [8][HIDDEN_SZ];
    logic [LW-1:0] bias_img [4];
    logic [LW-1:0] snap_ram [8][HIDDEN_SZ];
    logic [LW-1:0] snap_bias[4];

    // Position of word (block b, row r, column c) in the serial stream
    function automatic int word_idx(input int b, input int r, input int c);
        if (b < 8) return (b / 2) * PER_GATE + ((b % 2) ? INPUT_SZ * HIDDEN_SZ : 0)
                          + r * HIDDEN_SZ + c;
        return 4 * PER_GATE + (b - 8) * HIDDEN_SZ + c;
    endfunction

    function automatic int rows_of(input int b);
        if (b >= 8) return 1;
        return (b % 2) ? HIDDEN_SZ : INPUT_SZ;
    endfunction

    function automatic logic [LW-1:0] exp_row(input int base, input int b, input int r);
        logic [LW-1:0] v;
        v = '0;
        for (int c = 0; c < HIDDEN_SZ; c++) v[c*BW +: BW] = BW'(base + word_idx(b, r, c));
        return v;
    endfunction

    // Strobe monitor: every write strobe must match the head of the scoreboard
    exp_t          mon_e;
    bit            mon_ok;
    int            mon_bidx;
    logic [LW-1:0] mon_data;
    always @(negedge clock) begin
        if (wr_en === 1'b1 || bias_we !== 4'b0000) begin
            checks_total++;
            mon_data = (bias_we !== 4'b0000) ? bias_data : wr_data;
            if (exp_q.size() == 0) begin
                $display("FAIL strobe_unexpected: wr_en=%0b sel=%0d addr=%0d bias_we=%b, none expected",
                         wr_en, wr_sel, wr_addr, bias_we);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_bias)
                    mon_ok = (wr_en === 1'b0) && (bias_we === (4'b0001 << (mon_e.blk - 8)))
                             && (bias_data === mon_e.data);
                else
                    mon_ok = (wr_en === 1'b1) && (bias_we === 4'b0000)
                             && (wr_sel === 3'(mon_e.blk)) && (wr_addr === AW'(mon_e.row))
                             && (wr_data === mon_e.data);
                if (mon_ok) checks_passed++;
                else $display("FAIL strobe_blk%0d_row%0d: got wr_en=%0b sel=%0d addr=%0d bias_we=%b data=%h, want data=%h",
                              mon_e.blk, mon_e.row, wr_en, wr_sel, wr_addr, bias_we, mon_data,
                              mon_e.data);
            end
            if (wr_en === 1'b1) begin
                wr_cnt++;
                ram_img[wr_sel][wr_addr] = wr_data;
            end
            if (bias_we !== 4'b0000) begin
                bias_cnt++;
                case (bias_we)
                    4'b0001: mon_bidx = 0;
                    4'b0010: mon_bidx = 1;
                    4'b0100: mon_bidx = 2;
                    4'b1000: mon_bidx = 3;
                    default: mon_bidx = -1;
                endcase
                bias_order.push_back(mon_bidx);
                if (mon_bidx >= 0) bias_img[mon_bidx] = bias_data;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Drives the stream word k = base + k; pushes the expected write when a row completes
    task automatic drive_stream(input int base, input int gap_pct, input int start_at,
                                input int reset_at, output int n_acc, output int n_cyc,
                                output bit saw_done);
        int b = 0;
        int r = 0;
        int c = 0;
        bit acc;
        bit start_used = 1'b0;
        n_acc    = 0;
        n_cyc    = 0;
        saw_done = 1'b0;
        while (n_acc < TOTAL && n_cyc < 4000) begin
            @(negedge clock);
            n_cyc++;
            if (done === 1'b1) saw_done = 1'b1;
            if (n_acc == reset_at) begin
                reset    = 1'b1;
                in_valid = 1'b1;
                @(posedge clock);
                return;
            end
            start      = (n_acc == start_at) && !start_used;
            start_used = start_used || start;
            in_valid   = ($urandom_range(99) >= gap_pct);
            in_data    = BW'(base + n_acc);
            acc        = in_valid && in_ready;
            @(posedge clock);
            if (acc) begin
                if (c == HIDDEN_SZ - 1)
                    exp_q.push_back('{is_bias: (b >= 8), blk: b, row: r, data: exp_row(base, b, r)});
                n_acc++;
                c++;
                if (c == HIDDEN_SZ) begin
                    c = 0;
                    r++;
                    if (r == rows_of(b)) begin
                        r = 0;
                        b++;
                    end
                end
            end
        end
    endtask

    // Runs a complete load and checks completion timing and strobe totals
    task automatic full_load(input string tag, input int base, input int gap_pct,
                             input int start_at, input bit exact_len);
        int n;
        int cyc;
        bit early;
        wr_cnt   = 0;
        bias_cnt = 0;
        bias_order.delete();
        pulse_start();
        checks_total++;
        if (busy === 1'b1 && in_ready === 1'b1 && done === 1'b0) checks_passed++;
        else $display("FAIL %s_start: busy=%0b in_ready=%0b done=%0b, want 1 1 0",
                      tag, busy, in_ready, done);
        drive_stream(base, gap_pct, start_at, -1, n, cyc, early);
        checks_total++;
        if (n == TOTAL && !early) checks_passed++;
        else $display("FAIL %s_words: accepted %0d early_done=%0b, want %0d and 0",
                      tag, n, early, TOTAL);
        if (exact_len) begin
            checks_total++;
            if (cyc == TOTAL) checks_passed++;
            else $display("FAIL %s_duration: %0d cycles, want %0d", tag, cyc, TOTAL);
        end
        @(negedge clock);
        in_valid = 1'b0;
        checks_total++;
        if (done === 1'b1 && busy === 1'b0 && in_ready === 1'b0 && bias_we === 4'b1000)
            checks_passed++;
        else $display("FAIL %s_done: done=%0b busy=%0b in_ready=%0b bias_we=%b, want 1 0 0 1000",
                      tag, done, busy, in_ready, bias_we);
        #1;
        checks_total++;
        if (wr_cnt == NUM_WR && bias_cnt == 4 && exp_q.size() == 0) checks_passed++;
        else $display("FAIL %s_counts: wr=%0d bias=%0d pending=%0d, want %0d 4 0",
                      tag, wr_cnt, bias_cnt, exp_q.size(), NUM_WR);
        checks_total++;
        if (bias_order.size() == 4 && bias_order[0] == 0 && bias_order[1] == 1
            && bias_order[2] == 2 && bias_order[3] == 3) checks_passed++;
        else $display("FAIL %s_bias_order: got %0d strobes, want Z I F O", tag, bias_order.size());
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clock);
        checks_total++;
        if (in_ready === 1'b0 && wr_en === 1'b0 && wr_sel === 3'd0 && wr_addr === '0
            && wr_data === '0 && bias_we === 4'b0 && bias_data === '0 && busy === 1'b0
            && done === 1'b0) checks_passed++;
        else $display("FAIL reset_values: in_ready=%0b wr_en=%0b sel=%0d busy=%0b done=%0b, want all 0",
                      in_ready, wr_en, wr_sel, busy, done);
        reset = 1'b0;
    endtask

    task automatic test_idle_valid();
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_data  = BW'(i + 77);
            checks_total++;
            if (in_ready === 1'b0 && busy === 1'b0) checks_passed++;
            else $display("FAIL idle_valid: in_ready=%0b busy=%0b, want 0 0", in_ready, busy);
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic test_full_load();
        logic [LW-1:0] r0;
        logic [LW-1:0] r1;
        logic [LW-1:0] bo;
        full_load("full", 0, 0, -1, 1'b1);
        for (int j = 0; j < HIDDEN_SZ; j++) begin
            r0[j*BW +: BW] = BW'(j);
            r1[j*BW +: BW] = BW'(16 + j);
            bo[j*BW +: BW] = BW'(344 + j);
        end
        checks_total++;
        if (ram_img[0][0] === r0) checks_passed++;
        else $display("FAIL full_zx_row0: got %h, want %h", ram_img[0][0], r0);
        checks_total++;
        if (ram_img[1][0] === r1) checks_passed++;
        else $display("FAIL full_zy_row0: got %h, want %h", ram_img[1][0], r1);
        checks_total++;
        if (bias_img[3] === bo) checks_passed++;
        else $display("FAIL full_bias_o: got %h, want %h", bias_img[3], bo);
        snap_ram  = ram_img;
        snap_bias = bias_img;
    endtask

    task automatic test_gaps();
        int bad = 0;
        for (int s = 0; s < 8; s++)
            for (int a = 0; a < HIDDEN_SZ; a++) ram_img[s][a] = '0;
        for (int s = 0; s < 4; s++) bias_img[s] = '0;
        full_load("gaps", 0, 30, -1, 1'b0);
        for (int s = 0; s < 8; s++)
            for (int a = 0; a < rows_of(s); a++) if (ram_img[s][a] !== snap_ram[s][a]) bad++;
        for (int s = 0; s < 4; s++) if (bias_img[s] !== snap_bias[s]) bad++;
        checks_total++;
        if (bad == 0) checks_passed++;
        else $display("FAIL gaps_image: %0d rows differ from continuous load, want 0", bad);
    endtask

    task automatic test_start_ignored();
        full_load("start_mid", 0, 0, 100, 1'b1);
    endtask

    task automatic test_reset_midload();
        int n;
        int cyc;
        bit early;
        pulse_start();
        drive_stream(0, 0, -1, 200, n, cyc, early);
        @(negedge clock);
        checks_total++;
        if (n == 200 && in_ready === 1'b0 && wr_en === 1'b0 && wr_sel === 3'd0
            && wr_addr === '0 && wr_data === '0 && bias_we === 4'b0 && bias_data === '0
            && busy === 1'b0 && done === 1'b0) checks_passed++;
        else $display("FAIL midload_reset: words=%0d in_ready=%0b wr_en=%0b busy=%0b wr_data=%h, want 200 and reset values",
                      n, in_ready, wr_en, busy, wr_data);
        reset    = 1'b0;
        in_valid = 1'b0;
        checks_total++;
        if (exp_q.size() == 0) checks_passed++;
        else $display("FAIL midload_pending: %0d writes outstanding, want 0", exp_q.size());
        exp_q.delete();
        full_load("after_reset", 0, 0, -1, 1'b1);
    endtask

    task automatic test_done_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            checks_total++;
            if (in_ready === 1'b0 && done === 1'b1) checks_passed++;
            else $display("FAIL done_valid: in_ready=%0b done=%0b, want 0 1", in_ready, done);
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic test_reload();
        int bad = 0;
        full_load("reload", 1000, 0, -1, 1'b1);
        for (int s = 0; s < 8; s++)
            for (int a = 0; a < rows_of(s); a++) if (ram_img[s][a] !== exp_row(1000, s, a)) bad++;
        for (int s = 0; s < 4; s++) if (bias_img[s] !== exp_row(1000, 8 + s, 0)) bad++;
        checks_total++;
        if (bad == 0) checks_passed++;
        else $display("FAIL reload_image: %0d rows not overwritten correctly, want 0", bad);
    endtask

    initial begin
        test_reset();
        test_idle_valid();
        test_full_load();
        test_done_valid();
        test_gaps();
        test_start_ignored();
        test_reset_midload();
        test_reload();
        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
